// File: rtl/bias_group_sequencer_l17.sv
// Bias-bank select sequencer for the layer-17 8:1 bias mux: walks the output-channel
// groups of one pass, inserting a settle cycle after each select change.
module bias_group_sequencer_l17 #(
  parameter int N_GROUPS      = 8,
  parameter int PIX_PER_GROUP = 196,
  parameter int PIX_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 pix_done,
  output logic [2:0]           z,
  output logic                 bias_rdy,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           grp_idx,
  output logic [PIX_CNT_W-1:0] pix_cnt,
  output logic                 err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [2:0]           Z_LAST   = 3'(N_GROUPS - 1);
  localparam logic [PIX_CNT_W-1:0] PIX_LAST = PIX_CNT_W'(PIX_PER_GROUP - 1);

  state_t               state, state_nxt;
  logic [2:0]           z_nxt;
  logic [PIX_CNT_W-1:0] pix_nxt;
  logic                 err_nxt;
  logic                 done_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      z       <= 3'd0;
      pix_cnt <= '0;
      err     <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      z       <= z_nxt;
      pix_cnt <= pix_nxt;
      err     <= err_nxt;
      done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    z_nxt     = z;
    pix_nxt   = pix_cnt;
    err_nxt   = err;
    done_nxt  = 1'b0;
    // abort outranks everything; err survives it so the fault stays visible
    if (abort) begin
      state_nxt = IDLE;
      z_nxt     = 3'd0;
      pix_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = LOAD;
            z_nxt     = 3'd0;
            pix_nxt   = '0;
            err_nxt   = 1'b0;
          end
        end
        LOAD: begin
          // mux output not yet settled: a completion here used a stale bias
          state_nxt = RUN;
          if (pix_done) err_nxt = 1'b1;
        end
        RUN: begin
          if (pix_done) begin
            if (pix_cnt < PIX_LAST) begin
              pix_nxt = pix_cnt + PIX_CNT_W'(1);
            end else if (z < Z_LAST) begin
              z_nxt     = z + 3'd1;
              pix_nxt   = '0;
              state_nxt = LOAD;
            end else begin
              // final pixel: z and pix_cnt keep their last values
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy     = (state == LOAD) || (state == RUN);
  assign bias_rdy = (state == RUN);
  assign grp_idx  = z;

endmodule

// File: tb/tb_bias_group_sequencer_l17.sv
// Bench for bias_group_sequencer_l17: default-parameter instance plus a
// one-group/one-pixel instance, both checked every cycle against a pixel-index model.
module tb_bias_group_sequencer_l17;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start0, abort0, pd0, start1, abort1, pd1;
  logic [2:0] z0, grp0, z1, grp1;
  logic [7:0] pix0, pix1;
  logic       rdy0, busy0, done0, err0, rdy1, busy1, done1, err1;

  int total = 0;
  int bad   = 0;

  // model: position as a linear pixel index k within the pass
  bit m_act [2];
  bit m_set [2];
  bit m_err [2];
  bit m_done[2];
  int m_k   [2];
  int m_ng  [2] = '{8, 1};
  int m_ppg [2] = '{196, 1};

  bit p;
  int npix, nbub, ndone;

  always #5 clk = ~clk;

  bias_group_sequencer_l17 dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .pix_done(pd0),
    .z(z0), .bias_rdy(rdy0), .busy(busy0), .done(done0), .grp_idx(grp0),
    .pix_cnt(pix0), .err(err0)
  );

  bias_group_sequencer_l17 #(.N_GROUPS(1), .PIX_PER_GROUP(1), .PIX_CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .pix_done(pd1),
    .z(z1), .bias_rdy(rdy1), .busy(busy1), .done(done1), .grp_idx(grp1),
    .pix_cnt(pix1), .err(err1)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset(int i);
    m_act[i] = 0; m_set[i] = 0; m_err[i] = 0; m_done[i] = 0; m_k[i] = 0;
  endtask

  task automatic model_step(int i, bit s, bit a, bit pd);
    m_done[i] = 0;
    if (a) begin
      m_act[i] = 0; m_set[i] = 0; m_k[i] = 0;
    end else if (!m_act[i]) begin
      if (s) begin
        m_act[i] = 1; m_set[i] = 1; m_k[i] = 0; m_err[i] = 0;
      end
    end else if (m_set[i]) begin
      if (pd) m_err[i] = 1;
      m_set[i] = 0;
    end else if (pd) begin
      if (m_k[i] == m_ng[i] * m_ppg[i] - 1) begin
        m_act[i] = 0; m_done[i] = 1;
      end else begin
        m_k[i]++;
        if (m_k[i] % m_ppg[i] == 0) m_set[i] = 1;
      end
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ":busy0"}, busy0, m_act[0]);
    chk({tag, ":rdy0"},  rdy0,  m_act[0] && !m_set[0]);
    chk({tag, ":z0"},    z0,    m_k[0] / m_ppg[0]);
    chk({tag, ":grp0"},  grp0,  m_k[0] / m_ppg[0]);
    chk({tag, ":pix0"},  pix0,  m_k[0] % m_ppg[0]);
    chk({tag, ":done0"}, done0, m_done[0]);
    chk({tag, ":err0"},  err0,  m_err[0]);
    chk({tag, ":busy1"}, busy1, m_act[1]);
    chk({tag, ":rdy1"},  rdy1,  m_act[1] && !m_set[1]);
    chk({tag, ":z1"},    z1,    m_k[1] / m_ppg[1]);
    chk({tag, ":pix1"},  pix1,  m_k[1] % m_ppg[1]);
    chk({tag, ":done1"}, done1, m_done[1]);
    chk({tag, ":err1"},  err1,  m_err[1]);
  endtask

  // inputs are applied just after an edge and sampled at the next one
  task automatic cyc(bit s0, bit a0, bit p0, bit s1, bit a1, bit p1);
    start0 = s0; abort0 = a0; pd0 = p0;
    start1 = s1; abort1 = a1; pd1 = p1;
    @(posedge clk);
    model_step(0, s0, a0, p0);
    model_step(1, s1, a1, p1);
    #1;
    check_all("cyc");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    check_all("rst_async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all("rst_rel");
  endtask

  task automatic run_to(int target);
    for (int c = 0; c < 3000 && m_k[0] != target; c++)
      cyc(0, 0, m_act[0] && !m_set[0], 0, 0, 0);
    chk("run_to_pix", pix0, target % 196);
    chk("run_to_z", z0, target / 196);
  endtask

  initial begin
    rst_n = 1'b1;
    start0 = 0; abort0 = 0; pd0 = 0; start1 = 0; abort1 = 0; pd1 = 0;
    #2;
    do_reset();

    // idle boundaries: pix_done ignored, start+abort stays idle
    cyc(0, 0, 1, 0, 0, 1);
    chk("idle_pd_err0", err0, 0);
    cyc(1, 1, 0, 1, 1, 0);
    chk("start_abort_busy0", busy0, 0);
    chk("start_abort_busy1", busy1, 0);

    // full default pass, pix_done on every RUN cycle
    cyc(1, 0, 0, 0, 0, 0);
    chk("t1_load_busy", busy0, 1);
    chk("t1_load_rdy", rdy0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t1_rdy_t2", rdy0, 1);
    npix = 0; nbub = 0; ndone = 0;
    for (int c = 0; c < 2000 && ndone == 0; c++) begin
      p = m_act[0] && !m_set[0];
      if (p) npix++;
      cyc(0, 0, p, 0, 0, 0);
      if (busy0 && !rdy0) nbub++;
      if (done0) ndone++;
    end
    chk("t1_pixels", npix, 1568);
    chk("t1_bubbles", nbub, 7);
    chk("t1_done_cnt", ndone, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t1_done_low", done0, 0);
    chk("t1_hold_z", z0, 7);
    chk("t1_hold_pix", pix0, 195);

    // pix_done during LOAD sets sticky err
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("t2_err_set", err0, 1);
    chk("t2_pix_uncounted", pix0, 0);
    run_to(5);
    chk("t2_err_sticky", err0, 1);

    // start while busy is ignored
    run_to(3 * 196 + 50);
    cyc(1, 0, 0, 0, 0, 0);
    chk("t3_busy", busy0, 1);
    chk("t3_z", z0, 3);
    chk("t3_pix", pix0, 50);

    // abort mid-pass (with a simultaneous pix_done)
    run_to(5 * 196 + 100);
    cyc(0, 1, 1, 0, 0, 0);
    chk("t4_busy", busy0, 0);
    chk("t4_z", z0, 0);
    chk("t4_pix", pix0, 0);
    chk("t4_done", done0, 0);
    chk("t4_err_kept", err0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t4_no_done", done0, 0);

    // accepted start clears err; reset mid-RUN
    cyc(1, 0, 0, 0, 0, 0);
    chk("t2_err_cleared", err0, 0);
    run_to(300);
    do_reset();
    chk("t5_rst_z", z0, 0);
    chk("t5_rst_busy", busy0, 0);

    // random-gap full pass after reset
    cyc(1, 0, 0, 0, 0, 0);
    ndone = 0;
    for (int c = 0; c < 8000 && ndone == 0; c++) begin
      cyc(0, 0, $urandom_range(0, 3) != 0, 0, 0, 0);
      if (done0) ndone++;
    end
    chk("t5_done_cnt", ndone, 1);
    chk("t5_final_z", z0, 7);

    // single group, single pixel instance
    cyc(0, 0, 0, 1, 0, 0);
    chk("t6_busy", busy1, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t6_rdy", rdy1, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t6_done", done1, 1);
    chk("t6_z", z1, 0);
    chk("t6_busy_end", busy1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t6_done_low", done1, 0);

    // random mixed traffic on both instances
    for (int c = 0; c < 3000; c++)
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 499) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
